// File: rtl/barrett_reduction_pkg.sv
// Shared definitions for the Barrett modular multiplier: default data width,
// derived Barrett shift K and the controller state encoding.
package barrett_reduction_pkg;

    localparam int DATA_W_DEFAULT = 32;

    // Barrett shift amount: twice the operand width, so every a*b product
    // (at most 2*DATA_W bits) is covered by the estimate.
    function automatic int barrettK(input int dataW);
        return 2 * dataW;
    endfunction

    typedef enum logic [2:0] {
        IDLE,
        DIV,
        MUL,
        EST,
        SUB,
        CORR
    } state_t;

endpackage

// File: rtl/barrett_mu_div.sv
// Serial restoring divider that produces mu = floor(2^K / q) for the
// Barrett multiplier, one quotient bit per clock, K clocks per run.
//
// The dividend 2^K is a single one followed by K zeros. Its leading one can
// never produce a quotient bit for q >= 2. So the run starts with that one
// already in the remainder. The first of the K remaining bits is resolved on
// the start edge itself, and the other K-1 bits on the edges that follow.
// The done pulse therefore arrives exactly K cycles after start.
module barrett_mu_div
    import barrett_reduction_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [DATA_W-1:0]     i_q,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [2*DATA_W-1:0]   o_quotient
);

    localparam int K  = barrettK(DATA_W);
    localparam int CW = $clog2(K);
    localparam logic [DATA_W:0] TWO = (DATA_W + 1)'(2);

    logic [DATA_W-1:0] r_divisor;
    logic [DATA_W-1:0] r_rem;
    logic [K-1:0]      r_quot;
    logic [CW-1:0]     r_count;
    logic              r_busy;
    logic              r_done;

    logic [DATA_W:0]   w_divisorExt;
    logic [DATA_W:0]   w_remShift;
    logic              w_ge;
    logic [DATA_W:0]   w_startDivisorExt;
    logic              w_startGe;

    // One restoring step: shift in the next dividend bit (always zero here)
    // and compare against the divisor. The remainder stays below q, so the
    // shifted value needs only one extra bit.
    always_comb begin
        w_divisorExt      = {1'b0, r_divisor};
        w_remShift        = {r_rem, 1'b0};
        w_ge              = (w_remShift >= w_divisorExt);
        w_startDivisorExt = {1'b0, i_q};
        w_startGe         = (TWO >= w_startDivisorExt);
    end

    // Division sequencer: load and resolve the first bit on start, then
    // resolve one bit per cycle until all K quotient bits are in place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_divisor <= '0;
            r_rem     <= '0;
            r_quot    <= '0;
            r_count   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start && !r_busy) begin
                r_divisor <= i_q;
                r_rem     <= w_startGe ? DATA_W'(TWO - w_startDivisorExt) : DATA_W'(TWO);
                r_quot    <= {{(K-1){1'b0}}, w_startGe};
                r_count   <= CW'(K - 1);
                r_busy    <= 1'b1;
            end else if (r_busy) begin
                r_rem   <= w_ge ? DATA_W'(w_remShift - w_divisorExt) : w_remShift[DATA_W-1:0];
                r_quot  <= {r_quot[K-2:0], w_ge};
                r_count <= r_count - CW'(1);
                if (r_count == CW'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_quotient = r_quot;

endmodule

// File: rtl/barrett_reduction.sv
// Barrett modular multiplier: result = (a * b) mod q for a runtime modulus q.
// The unit handles one operation at a time. The Barrett constant
// mu = floor(2^K / q) is cached together with the q it belongs to. It is
// recomputed by the serial divider only when a new q >= 2 arrives.
module barrett_reduction
    import barrett_reduction_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] q,
    output logic              out_valid,
    output logic [DATA_W-1:0] result
);

    localparam int K  = barrettK(DATA_W);
    localparam int RW = K + 2;

    state_t            r_state;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_q;
    logic [K-1:0]      r_x;
    logic [K-1:0]      r_t;
    logic [RW-1:0]     r_r;
    logic [K-1:0]      r_mu;
    logic [DATA_W-1:0] r_qCache;
    logic              r_muValid;
    logic              r_inReady;
    logic              r_outValid;
    logic [DATA_W-1:0] r_result;

    logic              w_miss;
    logic              w_divStart;
    logic              w_divBusy;
    logic              w_divDone;
    logic [K-1:0]      w_divQuot;
    logic [K-1:0]      w_x;
    logic [2*K-1:0]    w_xmu;
    logic [K-1:0]      w_t;
    logic [RW-1:0]     w_tq;
    logic [RW-1:0]     w_rSub;
    logic [RW-1:0]     w_qExt;
    logic [RW-1:0]     w_r1;
    logic [RW-1:0]     w_r2;
    logic [DATA_W-1:0] w_resultNext;

    // Cache lookup on the incoming modulus. Only q >= 2 ever needs mu. The
    // degenerate moduli 0 and 1 take the short path and never disturb the
    // cached pair.
    always_comb begin
        w_miss     = (q >= DATA_W'(2)) && (!r_muValid || (q != r_qCache));
        w_divStart = (r_state == IDLE) && in_valid && w_miss;
    end

    barrett_mu_div #(
        .DATA_W (DATA_W)
    ) u_muDiv (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_divStart),
        .i_q        (q),
        .o_busy     (w_divBusy),
        .o_done     (w_divDone),
        .o_quotient (w_divQuot)
    );

    // Datapath for the multiply, estimate, subtract and correct stages. Each
    // stage reads only registers, so every stage boundary is a clean
    // register-to-register path. For q == 1, mu = 2^K cannot be stored, so
    // the estimate is forced to t = x, which makes the remainder zero.
    always_comb begin
        w_x    = {{DATA_W{1'b0}}, r_a} * {{DATA_W{1'b0}}, r_b};
        w_xmu  = {{K{1'b0}}, r_x} * {{K{1'b0}}, r_mu};
        w_t    = (r_q == DATA_W'(1)) ? r_x : K'(w_xmu >> K);
        w_tq   = {2'b00, r_t} * {{(RW-DATA_W){1'b0}}, r_q};
        w_rSub = {2'b00, r_x} - w_tq;
        w_qExt = {{(RW-DATA_W){1'b0}}, r_q};
        w_r1   = (r_r >= w_qExt) ? (r_r - w_qExt) : r_r;
        w_r2   = (w_r1 >= w_qExt) ? (w_r1 - w_qExt) : w_r1;
        w_resultNext = (r_q == '0) ? '0 : DATA_W'(w_r2);
    end

    // Controller: accepts an operation and waits for mu on a cache miss.
    // It then steps through the multiply/estimate/subtract/correct stages
    // and emits a one-cycle result pulse while going back to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_q        <= '0;
            r_x        <= '0;
            r_t        <= '0;
            r_r        <= '0;
            r_mu       <= '0;
            r_qCache   <= '0;
            r_muValid  <= 1'b0;
            r_inReady  <= 1'b1;
            r_outValid <= 1'b0;
            r_result   <= '0;
        end else begin
            r_outValid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a       <= a;
                        r_b       <= b;
                        r_q       <= q;
                        r_inReady <= 1'b0;
                        r_state   <= w_miss ? DIV : MUL;
                    end
                end
                DIV: begin
                    if (w_divDone && !w_divBusy) begin
                        r_mu      <= w_divQuot;
                        r_qCache  <= r_q;
                        r_muValid <= 1'b1;
                        r_state   <= MUL;
                    end
                end
                MUL: begin
                    r_x     <= w_x;
                    r_state <= EST;
                end
                EST: begin
                    r_t     <= w_t;
                    r_state <= SUB;
                end
                SUB: begin
                    r_r     <= w_rSub;
                    r_state <= CORR;
                end
                CORR: begin
                    r_result   <= w_resultNext;
                    r_outValid <= 1'b1;
                    r_inReady  <= 1'b1;
                    r_state    <= IDLE;
                end
                default: begin
                    r_inReady <= 1'b1;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_inReady;
    assign out_valid = r_outValid;
    assign result    = r_result;

endmodule

// File: tb/tb_barrett_reduction.sv
// Scoreboard bench for barrett_reduction: directed operations push their
// hand-computed result and latency into a queue, and an independent monitor
// pops and compares whenever out_valid is seen.
module tb_barrett_reduction;

    localparam int DATA_W   = 32;
    localparam int HIT_LAT  = 4;
    localparam int MISS_LAT = 4 + 2 * DATA_W;

    typedef struct {
        logic [DATA_W-1:0] res;
        int                lat;
        int                acceptCycle;
    } expEntry_t;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] q;
    logic              out_valid;
    logic [DATA_W-1:0] result;

    expEntry_t sbQueue[$];
    int        cycleCount = 0;
    int        checkCount = 0;
    int        passCount  = 0;

    barrett_reduction #(
        .DATA_W (DATA_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .q         (q),
        .out_valid (out_valid),
        .result    (result)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter used to measure acceptance-to-result latency
    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (time %0t)", name, actual, expected, $time);
        end
    endtask

    // Issue one operation once the DUT is ready. If track is set, the
    // expected result and latency are queued for the monitor.
    task automatic applyStimulus(input logic [DATA_W-1:0] ta, input logic [DATA_W-1:0] tb,
                                 input logic [DATA_W-1:0] tq, input logic [DATA_W-1:0] expRes,
                                 input int expLat, input bit track);
        int waitCycles;
        expEntry_t e;
        waitCycles = 0;
        @(negedge clk);
        while (!in_ready && waitCycles < 500) begin
            @(negedge clk);
            waitCycles++;
        end
        checkOutput("in_ready_before_issue", 64'(in_ready), 64'(1));
        if (in_ready) begin
            a        = ta;
            b        = tb;
            q        = tq;
            in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            if (track) begin
                e.res         = expRes;
                e.lat         = expLat;
                e.acceptCycle = cycleCount;
                sbQueue.push_back(e);
            end
        end
    endtask

    // Monitor: every out_valid pulse must match the oldest queued expectation
    always @(negedge clk) begin : monitor
        expEntry_t e;
        if (!rst && out_valid) begin
            if (sbQueue.size() == 0) begin
                checkOutput("unexpected_out_valid", 64'(out_valid), 64'(0));
            end else begin
                e = sbQueue.pop_front();
                checkOutput("result", 64'(result), 64'(e.res));
                checkOutput("latency", 64'(cycleCount - e.acceptCycle), 64'(e.lat));
            end
        end
    end

    // Global time limit so the run can never hang
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus sequence
    initial begin
        int drainCycles;
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        q        = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_in_ready", 64'(in_ready), 64'(1));
        checkOutput("reset_out_valid", 64'(out_valid), 64'(0));
        checkOutput("reset_result", 64'(result), 64'(0));

        // Cold cache miss, then the same operation hits
        applyStimulus(32'd4571, 32'd4712, 32'd7681, 32'd1028, MISS_LAT, 1'b1);
        applyStimulus(32'd4571, 32'd4712, 32'd7681, 32'd1028, HIT_LAT, 1'b1);

        // (q-1)^2 mod q, then the smallest real modulus q=2 (mu = 2^63)
        applyStimulus(32'd7680, 32'd7680, 32'd7681, 32'd1, HIT_LAT, 1'b1);
        applyStimulus(32'd3, 32'd5, 32'd2, 32'd1, MISS_LAT, 1'b1);

        // Full-width operands against large moduli
        applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'd1, MISS_LAT, 1'b1);
        applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, MISS_LAT, 1'b1);

        // Degenerate moduli leave the q=7681 cache entry intact
        applyStimulus(32'd4571, 32'd4712, 32'd7681, 32'd1028, MISS_LAT, 1'b1);
        applyStimulus(32'd123, 32'd456, 32'd1, 32'd0, HIT_LAT, 1'b1);
        applyStimulus(32'd123, 32'd456, 32'd0, 32'd0, HIT_LAT, 1'b1);
        applyStimulus(32'd7680, 32'd2, 32'd7681, 32'd7679, HIT_LAT, 1'b1);
        applyStimulus(32'd0, 32'd12345, 32'd7681, 32'd0, HIT_LAT, 1'b1);

        // Requests during a divider run are ignored
        applyStimulus(32'd100, 32'd200, 32'd12289, 32'd7711, MISS_LAT, 1'b1);
        a        = 32'd1;
        b        = 32'd1;
        q        = 32'd3;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("in_ready_during_div", 64'(in_ready), 64'(0));
        end
        in_valid = 1'b0;

        // Reset in the middle of a divider run aborts it and clears the cache
        applyStimulus(32'd4571, 32'd4712, 32'd7681, 32'd0, MISS_LAT, 1'b0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("abort_out_valid", 64'(out_valid), 64'(0));
        checkOutput("abort_result", 64'(result), 64'(0));
        checkOutput("abort_in_ready", 64'(in_ready), 64'(1));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (80) @(negedge clk);
        applyStimulus(32'd100, 32'd200, 32'd12289, 32'd7711, MISS_LAT, 1'b1);
        applyStimulus(32'd4571, 32'd4712, 32'd7681, 32'd1028, MISS_LAT, 1'b1);

        // Let outstanding results drain, bounded
        drainCycles = 0;
        while (sbQueue.size() != 0 && drainCycles < 300) begin
            @(negedge clk);
            drainCycles++;
        end
        checkOutput("scoreboard_drained", 64'(sbQueue.size()), 64'(0));
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
